// File: rtl/lfsr_checker.sv
// Receive-side checker for the 8-bit pattern generator: self-syncs, flags/counts mismatches, folds words into a MISR.
// Optional sticky failure flag enabled by defining LFSR_CHK_STICKY_EN.
//
// state  | meaning
// HUNT   | waiting for a nonzero word to seed the predictor
// SYNC   | counting consecutive correct predictions toward lock
// LOCKED | flywheel prediction, error counting and signature compression
module lfsr_checker #(
    parameter int LOCK_CNT = 4,
    parameter int LOSS_CNT = 3,
    parameter int CNT_W    = 16
) (
    input  logic             clk,
    input  logic             set,
    input  logic             clear,
    input  logic [7:0]       din,
    input  logic             din_vld,
    output logic             locked,
    output logic             err,
    output logic [CNT_W-1:0] err_cnt,
    output logic [7:0]       sig,
    output logic             fail
);

    typedef enum logic [1:0] {HUNT, SYNC, LOCKED} state_t;

    localparam logic [3:0]       LOCK_LAST = 4'(LOCK_CNT - 1);
    localparam logic [3:0]       LOSS_LAST = 4'(LOSS_CNT - 1);
    localparam logic [CNT_W-1:0] ERR_MAX   = '1;

    function automatic logic [7:0] next_pat(input logic [7:0] w);
        return {w[7] ^ w[0], w[7:1]};
    endfunction

    state_t           state, state_n;
    logic [7:0]       pred, pred_n;
    logic [3:0]       match_cnt, match_cnt_n;
    logic [3:0]       miss_cnt, miss_cnt_n;
    logic             locked_n, err_n;
    logic [CNT_W-1:0] err_cnt_n;
    logic [7:0]       sig_n;

    always_comb begin
        state_n     = state;
        pred_n      = pred;
        match_cnt_n = match_cnt;
        miss_cnt_n  = miss_cnt;
        locked_n    = locked;
        err_n       = 1'b0;
        err_cnt_n   = err_cnt;
        sig_n       = sig;
        case (state)
            HUNT: begin
                if (din_vld && din != 8'h00) begin
                    pred_n      = next_pat(din);
                    match_cnt_n = 4'd0;
                    state_n     = SYNC;
                end
            end
            SYNC: begin
                if (din_vld) begin
                    if (din == 8'h00) begin
                        state_n = HUNT;
                    end else if (din == pred) begin
                        pred_n      = next_pat(din);
                        match_cnt_n = match_cnt + 4'd1;
                        if (match_cnt == LOCK_LAST) begin
                            state_n    = LOCKED;
                            locked_n   = 1'b1;
                            miss_cnt_n = 4'd0;
                        end
                    end else begin
                        pred_n      = next_pat(din);
                        match_cnt_n = 4'd0;
                    end
                end
            end
            LOCKED: begin
                // Flywheel: the predictor free-runs so corrupted words cannot re-seed it.
                if (din_vld) begin
                    pred_n = next_pat(pred);
                    sig_n  = next_pat(sig) ^ din;
                    if (din == pred) begin
                        miss_cnt_n = 4'd0;
                    end else begin
                        err_n = 1'b1;
                        if (err_cnt != ERR_MAX)
                            err_cnt_n = err_cnt + 1'b1;
                        if (miss_cnt == LOSS_LAST) begin
                            state_n    = HUNT;
                            locked_n   = 1'b0;
                            miss_cnt_n = 4'd0;
                        end else begin
                            miss_cnt_n = miss_cnt + 4'd1;
                        end
                    end
                end
            end
            default: state_n = HUNT;
        endcase
    end

    always_ff @(posedge clk or posedge set) begin
        if (set) begin
            state     <= HUNT;
            pred      <= 8'h00;
            match_cnt <= 4'd0;
            miss_cnt  <= 4'd0;
            locked    <= 1'b0;
            err       <= 1'b0;
            err_cnt   <= '0;
            sig       <= 8'h00;
        end else if (clear) begin
            state     <= HUNT;
            pred      <= 8'h00;
            match_cnt <= 4'd0;
            miss_cnt  <= 4'd0;
            locked    <= 1'b0;
            err       <= 1'b0;
            err_cnt   <= '0;
            sig       <= 8'h00;
        end else begin
            state     <= state_n;
            pred      <= pred_n;
            match_cnt <= match_cnt_n;
            miss_cnt  <= miss_cnt_n;
            locked    <= locked_n;
            err       <= err_n;
            err_cnt   <= err_cnt_n;
            sig       <= sig_n;
        end
    end

`ifdef LFSR_CHK_STICKY_EN
    // Sticky flag rises with the err pulse or the locked fall that caused it.
    always_ff @(posedge clk or posedge set) begin
        if (set)
            fail <= 1'b0;
        else if (clear)
            fail <= 1'b0;
        else
            fail <= fail | err_n | (locked & ~locked_n);
    end
`else
    assign fail = 1'b0;
`endif

endmodule

// File: tb/tb_lfsr_checker.sv
// Directed self-checking bench for lfsr_checker: default instance plus a CNT_W=2 / LOSS_CNT=15 instance for saturation.
module tb_lfsr_checker;

    logic       clk = 1'b0;
    logic       set = 1'b1;
    logic       clear = 1'b0;
    logic [7:0] din = 8'h00;
    logic       din_vld = 1'b0;

    logic        locked, err, fail;
    logic [15:0] err_cnt;
    logic [7:0]  sig;
    logic        s_locked, s_err, s_fail;
    logic [1:0]  s_err_cnt;
    logic [7:0]  s_sig;

    int tests = 0;
    int fails = 0;

`ifdef LFSR_CHK_STICKY_EN
    localparam logic STICKY = 1'b1;
`else
    localparam logic STICKY = 1'b0;
`endif

    lfsr_checker dut (
        .clk(clk), .set(set), .clear(clear), .din(din), .din_vld(din_vld),
        .locked(locked), .err(err), .err_cnt(err_cnt), .sig(sig), .fail(fail)
    );

    lfsr_checker #(.LOCK_CNT(4), .LOSS_CNT(15), .CNT_W(2)) dut_s (
        .clk(clk), .set(set), .clear(clear), .din(din), .din_vld(din_vld),
        .locked(s_locked), .err(s_err), .err_cnt(s_err_cnt), .sig(s_sig), .fail(s_fail)
    );

    always #5 clk = ~clk;

    task automatic feed(input logic [7:0] d);
        @(negedge clk);
        din = d;
        din_vld = 1'b1;
        @(posedge clk);
        #1;
        din_vld = 1'b0;
    endtask

    task automatic idle();
        @(negedge clk);
        din = 8'h99;
        din_vld = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic do_clear(input logic vld, input logic [7:0] d);
        @(negedge clk);
        clear = 1'b1;
        din_vld = vld;
        din = d;
        @(posedge clk);
        #1;
        clear = 1'b0;
        din_vld = 1'b0;
    endtask

    task automatic lock_seq();
        feed(8'hFF); feed(8'h7F); feed(8'hBF); feed(8'h5F); feed(8'hAF);
    endtask

    task automatic test_reset();
        #1;
        tests++; if ({locked, err, err_cnt, sig, fail} !== 27'd0) begin
            fails++; $display("FAIL reset_outputs: got %h, want 0", {locked, err, err_cnt, sig, fail}); end
        @(negedge clk);
        set = 1'b0;
    endtask

    task automatic test_clean_lock();
        feed(8'hFF); feed(8'h7F); feed(8'hBF); feed(8'h5F);
        tests++; if (locked !== 1'b0) begin
            fails++; $display("FAIL clean_prelock: locked=%b want 0", locked); end
        feed(8'hAF);
        tests++; if (locked !== 1'b1) begin
            fails++; $display("FAIL clean_lock: locked=%b want 1", locked); end
        feed(8'h57);
        tests++; if (err !== 1'b0 || sig !== 8'h57) begin
            fails++; $display("FAIL clean_57: err=%b sig=%h want 0/57", err, sig); end
        feed(8'hAB);
        tests++; if (err !== 1'b0 || err_cnt !== 16'd0 || sig !== 8'h00) begin
            fails++; $display("FAIL clean_ab: err=%b cnt=%0d sig=%h want 0/0/00", err, err_cnt, sig); end
    endtask

    task automatic test_single_error();
        do_clear(1'b0, 8'h00);
        lock_seq();
        feed(8'h00);
        tests++; if (err !== 1'b1 || err_cnt !== 16'd1 || locked !== 1'b1 || fail !== STICKY) begin
            fails++; $display("FAIL single_err: err=%b cnt=%0d locked=%b fail=%b want 1/1/1/%b", err, err_cnt, locked, fail, STICKY); end
        feed(8'hAB);
        tests++; if (err !== 1'b0 || err_cnt !== 16'd1 || locked !== 1'b1 || sig !== 8'hAB || fail !== STICKY) begin
            fails++; $display("FAIL single_after: err=%b cnt=%0d locked=%b sig=%h fail=%b want 0/1/1/AB/%b", err, err_cnt, locked, sig, fail, STICKY); end
    endtask

    task automatic test_reset_midstream();
        @(negedge clk);
        set = 1'b1;
        #1;
        tests++; if ({locked, err, err_cnt, sig, fail} !== 27'd0) begin
            fails++; $display("FAIL reset_mid: got %h, want 0", {locked, err, err_cnt, sig, fail}); end
        @(negedge clk);
        set = 1'b0;
    endtask

    task automatic test_loss_of_lock();
        lock_seq();
        feed(8'h12);
        tests++; if (err !== 1'b1 || err_cnt !== 16'd1 || locked !== 1'b1) begin
            fails++; $display("FAIL loss_1: err=%b cnt=%0d locked=%b want 1/1/1", err, err_cnt, locked); end
        idle();
        tests++; if (err !== 1'b0 || err_cnt !== 16'd1 || locked !== 1'b1 || sig !== 8'h12) begin
            fails++; $display("FAIL loss_idle: err=%b cnt=%0d locked=%b sig=%h want 0/1/1/12", err, err_cnt, locked, sig); end
        feed(8'h34);
        tests++; if (err !== 1'b1 || err_cnt !== 16'd2 || locked !== 1'b1) begin
            fails++; $display("FAIL loss_2: err=%b cnt=%0d locked=%b want 1/2/1", err, err_cnt, locked); end
        feed(8'h56);
        tests++; if (err !== 1'b1 || err_cnt !== 16'd3 || locked !== 1'b0 || sig !== 8'hC8 || fail !== STICKY) begin
            fails++; $display("FAIL loss_3: err=%b cnt=%0d locked=%b sig=%h fail=%b want 1/3/0/C8/%b", err, err_cnt, locked, sig, fail, STICKY); end
        feed(8'h5F); feed(8'hAF); feed(8'h57); feed(8'hAB);
        tests++; if (locked !== 1'b0 || err !== 1'b0) begin
            fails++; $display("FAIL relock_early: locked=%b err=%b want 0/0", locked, err); end
        feed(8'h55);
        tests++; if (locked !== 1'b1 || err_cnt !== 16'd3 || sig !== 8'hC8) begin
            fails++; $display("FAIL relock: locked=%b cnt=%0d sig=%h want 1/3/C8", locked, err_cnt, sig); end
    endtask

    task automatic test_hunt();
        do_clear(1'b0, 8'h00);
        for (int i = 0; i < 5; i++) feed(8'h00);
        tests++; if (locked !== 1'b0) begin
            fails++; $display("FAIL hunt_zeros: locked=%b want 0", locked); end
        feed(8'hFF); feed(8'h7F); feed(8'h00);
        tests++; if (locked !== 1'b0 || err !== 1'b0 || err_cnt !== 16'd0) begin
            fails++; $display("FAIL sync_zero: locked=%b err=%b cnt=%0d want 0/0/0", locked, err, err_cnt); end
        feed(8'hBF); feed(8'h5F); feed(8'hAF); feed(8'h57);
        tests++; if (locked !== 1'b0) begin
            fails++; $display("FAIL hunt_reseed: locked=%b want 0", locked); end
        feed(8'hAB);
        tests++; if (locked !== 1'b1 || err_cnt !== 16'd0) begin
            fails++; $display("FAIL hunt_lock: locked=%b cnt=%0d want 1/0", locked, err_cnt); end
    endtask

    task automatic test_saturation_clear();
        do_clear(1'b0, 8'h00);
        lock_seq();
        for (int i = 0; i < 5; i++) feed(8'h12);
        tests++; if (s_err_cnt !== 2'd3 || s_err !== 1'b1 || s_locked !== 1'b1 || s_fail !== STICKY) begin
            fails++; $display("FAIL sat: cnt=%0d err=%b locked=%b fail=%b want 3/1/1/%b", s_err_cnt, s_err, s_locked, s_fail, STICKY); end
        do_clear(1'b1, 8'hFF);
        tests++; if ({s_locked, s_err, s_err_cnt, s_sig, s_fail} !== 13'd0) begin
            fails++; $display("FAIL clear_s: got %h want 0", {s_locked, s_err, s_err_cnt, s_sig, s_fail}); end
        tests++; if ({locked, err, err_cnt, sig, fail} !== 27'd0) begin
            fails++; $display("FAIL clear_d: got %h want 0", {locked, err, err_cnt, sig, fail}); end
        feed(8'h7F); feed(8'hBF); feed(8'h5F); feed(8'hAF);
        tests++; if (s_locked !== 1'b0) begin
            fails++; $display("FAIL clear_drop: locked=%b want 0", s_locked); end
        feed(8'h57);
        tests++; if (s_locked !== 1'b1) begin
            fails++; $display("FAIL clear_relock: locked=%b want 1", s_locked); end
    endtask

    initial begin
        test_reset();
        test_clean_lock();
        test_single_error();
        test_reset_midstream();
        test_loss_of_lock();
        test_hunt();
        test_saturation_clear();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
